// File: rtl/harvos_pkg.sv
// rtl/harvos_pkg.sv - shared privilege, access-type and fault-cause types
// Purpose: types shared by the MPU, the MPU request arbiter and the trap/CSR logic.
// Contents: priv_e, fault_cause_e, acc_type_e, MMIO_BASE, cause_of().
package harvos_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_M = 2'b11
  } priv_e;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_EXEC  = 2'd1,
    FC_LOAD  = 2'd2,
    FC_STORE = 2'd3
  } fault_cause_e;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } acc_type_e;

  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

  function automatic fault_cause_e cause_of(input acc_type_e acc);
    case (acc)
      ACC_FETCH: return FC_EXEC;
      ACC_LOAD:  return FC_LOAD;
      ACC_STORE: return FC_STORE;
      default:   return FC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mpu_req_arbiter_if.sv
// rtl/mpu_req_arbiter_if.sv - request/response bundle for the IF and LS check ports
// Purpose: groups both requester handshakes of the MPU request arbiter.
// Ports: if_req_* / if_rsp_* (fetch side), ls_req_* / ls_rsp_* (load/store side).
// Modports: master = requesters, slave = arbiter.
interface mpu_req_arbiter_if;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic        if_rsp_fault;
  logic        ls_req_valid;
  logic [31:0] ls_req_addr;
  logic        ls_req_we;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic        ls_rsp_fault;

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_fault,
    output ls_req_valid, ls_req_addr, ls_req_we,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_fault
  );

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_fault,
    input  ls_req_valid, ls_req_addr, ls_req_we,
    output ls_req_ready, ls_rsp_valid, ls_rsp_fault
  );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a last-grant register
// Purpose: grants a lone requester directly; on a tie grants the one not served last.
// Ports: clk, rst_n (async active-low), req[1:0], update (grant consumed this cycle),
//        gnt[1:0] (combinational, one-hot or zero).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 0 = req[0] served last, 1 = req[1] served last; reset favours req[0] on the first tie
  logic last_grant;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/mpu_req_arbiter.sv
// rtl/mpu_req_arbiter.sv - shares one MPU checker between fetch and load/store ports
// Purpose: round-robin accepts one check at a time, holds MPU inputs for MPU_LAT cycles,
//          returns a one-cycle response and records the last fault plus a saturating count.
// Ports: clk, rst_n, cur_priv; bus (IF/LS request/response, slave side);
//        mpu_addr/mpu_is_*/mpu_cur_priv to the MPU, mpu_allow/mpu_fault_* from it;
//        fault_addr/fault_cause/fault_priv/fault_cnt to trap/CSR logic.
module mpu_req_arbiter
  import harvos_pkg::*;
#(
  parameter int unsigned MPU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  priv_e               cur_priv,
  mpu_req_arbiter_if.slave    bus,
  output logic [31:0]         mpu_addr,
  output logic                mpu_is_fetch,
  output logic                mpu_is_load,
  output logic                mpu_is_store,
  output priv_e               mpu_cur_priv,
  input  logic                mpu_allow,
  input  logic                mpu_fault_exec,
  input  logic                mpu_fault_load,
  input  logic                mpu_fault_store,
  output logic [31:0]         fault_addr,
  output fault_cause_e        fault_cause,
  output priv_e               fault_priv,
  output logic [CNT_W-1:0]    fault_cnt
);

  localparam int unsigned LAT_W = (MPU_LAT > 1) ? $clog2(MPU_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RESP} state_e;

  state_e             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic               sel_ls;
  acc_type_e          acc;
  logic [1:0]         req;
  logic [1:0]         gnt;
  logic               accept;
  acc_type_e          acc_next;
  logic               fault_now;

  // Requests are only offered to the arbiter in IDLE, so gnt doubles as ready.
  assign req = {bus.ls_req_valid, bus.if_req_valid} & {2{state == S_IDLE}};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (accept),
    .gnt    (gnt)
  );

  assign bus.if_req_ready = gnt[0];
  assign bus.ls_req_ready = gnt[1];
  assign accept           = |gnt;
  assign acc_next         = gnt[0] ? ACC_FETCH : (bus.ls_req_we ? ACC_STORE : ACC_LOAD);

  // Only the fault flag matching the in-flight access type counts.
  assign fault_now = !mpu_allow
                   | (mpu_is_fetch & mpu_fault_exec)
                   | (mpu_is_load  & mpu_fault_load)
                   | (mpu_is_store & mpu_fault_store);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      lat_cnt          <= '0;
      sel_ls           <= 1'b0;
      acc              <= ACC_FETCH;
      mpu_addr         <= '0;
      mpu_cur_priv     <= PRIV_M;
      mpu_is_fetch     <= 1'b0;
      mpu_is_load      <= 1'b0;
      mpu_is_store     <= 1'b0;
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_fault <= 1'b0;
      bus.ls_rsp_valid <= 1'b0;
      bus.ls_rsp_fault <= 1'b0;
      fault_addr       <= '0;
      fault_cause      <= FC_NONE;
      fault_priv       <= PRIV_M;
      fault_cnt        <= '0;
    end else begin
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_fault <= 1'b0;
      bus.ls_rsp_valid <= 1'b0;
      bus.ls_rsp_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sel_ls       <= gnt[1];
            acc          <= acc_next;
            mpu_addr     <= gnt[1] ? bus.ls_req_addr : bus.if_req_addr;
            mpu_cur_priv <= cur_priv;
            mpu_is_fetch <= (acc_next == ACC_FETCH);
            mpu_is_load  <= (acc_next == ACC_LOAD);
            mpu_is_store <= (acc_next == ACC_STORE);
            lat_cnt      <= LAT_W'(MPU_LAT - 1);
            state        <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (lat_cnt == '0) begin
            mpu_is_fetch     <= 1'b0;
            mpu_is_load      <= 1'b0;
            mpu_is_store     <= 1'b0;
            bus.if_rsp_valid <= !sel_ls;
            bus.if_rsp_fault <= !sel_ls & fault_now;
            bus.ls_rsp_valid <= sel_ls;
            bus.ls_rsp_fault <= sel_ls & fault_now;
            if (fault_now) begin
              fault_addr  <= mpu_addr;
              fault_cause <= cause_of(acc);
              fault_priv  <= mpu_cur_priv;
              if (fault_cnt != '1) fault_cnt <= fault_cnt + CNT_W'(1);
            end
            state <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_req_arbiter.sv
// tb/tb_mpu_req_arbiter.sv - self-checking bench for mpu_req_arbiter
module tb_mpu_req_arbiter;
  import harvos_pkg::*;

  logic clk;
  logic rst_n;
  priv_e cur_priv;

  mpu_req_arbiter_if bus1 ();
  mpu_req_arbiter_if bus2 ();

  logic [31:0]  m1_addr, m2_addr;
  logic         m1_isf, m1_isl, m1_iss, m2_isf, m2_isl, m2_iss;
  priv_e        m1_priv, m2_priv;
  logic         m1_allow, m1_fe, m1_fl, m1_fs, m2_allow, m2_fe, m2_fl, m2_fs;
  logic [31:0]  f1_addr, f2_addr;
  fault_cause_e f1_cause, f2_cause;
  priv_e        f1_priv, f2_priv;
  logic [15:0]  f1_cnt;
  logic [1:0]   f2_cnt;

  int checks = 0;
  int errors = 0;

  // MPU stand-in: U-mode is denied the MMIO region; region 0x2xxx_xxxx raises
  // fault_store for every access type, so a non-store there must still be allowed.
  function automatic logic [3:0] mpu_model(input logic [31:0] a, input priv_e p,
                                           input logic f, input logic l, input logic s);
    logic allow;
    allow = !((p == PRIV_U) && (a[31:28] == MMIO_BASE[31:28]));
    return {allow, f & !allow, l & !allow, (s & !allow) | (a[31:28] == 4'h2)};
  endfunction

  assign {m1_allow, m1_fe, m1_fl, m1_fs} = mpu_model(m1_addr, m1_priv, m1_isf, m1_isl, m1_iss);
  assign {m2_allow, m2_fe, m2_fl, m2_fs} = mpu_model(m2_addr, m2_priv, m2_isf, m2_isl, m2_iss);

  mpu_req_arbiter #(.MPU_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .cur_priv(cur_priv), .bus(bus1),
    .mpu_addr(m1_addr), .mpu_is_fetch(m1_isf), .mpu_is_load(m1_isl), .mpu_is_store(m1_iss),
    .mpu_cur_priv(m1_priv), .mpu_allow(m1_allow), .mpu_fault_exec(m1_fe),
    .mpu_fault_load(m1_fl), .mpu_fault_store(m1_fs),
    .fault_addr(f1_addr), .fault_cause(f1_cause), .fault_priv(f1_priv), .fault_cnt(f1_cnt)
  );

  mpu_req_arbiter #(.MPU_LAT(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cur_priv(cur_priv), .bus(bus2),
    .mpu_addr(m2_addr), .mpu_is_fetch(m2_isf), .mpu_is_load(m2_isl), .mpu_is_store(m2_iss),
    .mpu_cur_priv(m2_priv), .mpu_allow(m2_allow), .mpu_fault_exec(m2_fe),
    .mpu_fault_load(m2_fl), .mpu_fault_store(m2_fs),
    .fault_addr(f2_addr), .fault_cause(f2_cause), .fault_priv(f2_priv), .fault_cnt(f2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         port;   // 0 = IF, 1 = LS
    logic         we;
    priv_e        priv;
    logic [31:0]  addr;
    logic         fault;
    logic [31:0]  f_addr;
    fault_cause_e cause;
    priv_e        f_priv;
    int           cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ready"},    {bus1.if_req_ready, bus1.ls_req_ready}, 0);
    chk({tag, " rsp"},      {bus1.if_rsp_valid, bus1.ls_rsp_valid}, 0);
    chk({tag, " mpu_is"},   {m1_isf, m1_isl, m1_iss}, 0);
    chk({tag, " mpu_addr"}, m1_addr, 0);
    chk({tag, " mpu_priv"}, m1_priv, PRIV_M);
    chk({tag, " f_addr"},   f1_addr, 0);
    chk({tag, " f_cause"},  f1_cause, FC_NONE);
    chk({tag, " f_priv"},   f1_priv, PRIV_M);
    chk({tag, " f_cnt"},    f1_cnt, 0);
  endtask

  // Single request on dut1 with no competitor; MPU_LAT = 1 so the response is
  // expected at the second negedge after the handshake edge.
  task automatic run_req(input logic port, input logic we, input priv_e pr, input logic [31:0] addr,
                         input logic switch_priv, input logic exp_fault, input string tag);
    int n;
    int k;
    @(negedge clk);
    cur_priv = pr;
    if (port) begin
      bus1.ls_req_valid = 1'b1; bus1.ls_req_addr = addr; bus1.ls_req_we = we;
    end else begin
      bus1.if_req_valid = 1'b1; bus1.if_req_addr = addr;
    end
    #1;
    n = 0;
    while (!(port ? bus1.ls_req_ready : bus1.if_req_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, " accept wait"}, n, 0);
    @(negedge clk);
    bus1.if_req_valid = 1'b0;
    bus1.ls_req_valid = 1'b0;
    if (switch_priv) cur_priv = PRIV_M;
    #1;
    chk({tag, " mpu_is"}, {m1_isf, m1_isl, m1_iss}, port ? (we ? 3'b001 : 3'b010) : 3'b100);
    chk({tag, " mpu_addr"}, m1_addr, addr);
    chk({tag, " mpu_priv"}, m1_priv, pr);
    k = 1;
    while (!(bus1.if_rsp_valid || bus1.ls_rsp_valid) && k < 20) begin
      @(negedge clk); k++;
    end
    chk({tag, " latency"}, k, 2);
    chk({tag, " rsp port"}, {bus1.if_rsp_valid, bus1.ls_rsp_valid}, port ? 2'b01 : 2'b10);
    chk({tag, " rsp fault"}, port ? bus1.ls_rsp_fault : bus1.if_rsp_fault, exp_fault);
    @(negedge clk);
    chk({tag, " pulse end"}, {bus1.if_rsp_valid, bus1.ls_rsp_valid}, 0);
  endtask

  initial begin
    int if_sent, ls_sent, gi, ri, k;
    logic adv_if, adv_ls;

    vecs[0] = '{1'b1, 1'b0, PRIV_M, 32'h1000_0000, 1'b0, 32'h0,         FC_NONE,  PRIV_M, 0};
    vecs[1] = '{1'b1, 1'b1, PRIV_U, 32'h1000_0000, 1'b1, 32'h1000_0000, FC_STORE, PRIV_U, 1};
    vecs[2] = '{1'b0, 1'b0, PRIV_M, 32'h0000_0400, 1'b0, 32'h1000_0000, FC_STORE, PRIV_U, 1};
    vecs[3] = '{1'b0, 1'b0, PRIV_U, 32'h1000_0040, 1'b1, 32'h1000_0040, FC_EXEC,  PRIV_U, 2};
    vecs[4] = '{1'b1, 1'b0, PRIV_U, 32'h1000_0080, 1'b1, 32'h1000_0080, FC_LOAD,  PRIV_U, 3};
    vecs[5] = '{1'b1, 1'b0, PRIV_M, 32'h2000_0000, 1'b0, 32'h1000_0080, FC_LOAD,  PRIV_U, 3};
    vecs[6] = '{1'b1, 1'b1, PRIV_M, 32'h2000_0004, 1'b1, 32'h2000_0004, FC_STORE, PRIV_M, 4};
    vecs[7] = '{1'b0, 1'b0, PRIV_U, 32'h0000_0100, 1'b0, 32'h2000_0004, FC_STORE, PRIV_M, 4};

    rst_n = 1'b0;
    cur_priv = PRIV_M;
    bus1.if_req_valid = 1'b0; bus1.if_req_addr = '0;
    bus1.ls_req_valid = 1'b0; bus1.ls_req_addr = '0; bus1.ls_req_we = 1'b0;
    bus2.if_req_valid = 1'b0; bus2.if_req_addr = '0;
    bus2.ls_req_valid = 1'b0; bus2.ls_req_addr = '0; bus2.ls_req_we = 1'b0;

    repeat (2) @(negedge clk);
    #1 chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports request together, three times each, holding until accepted.
    @(negedge clk);
    cur_priv = PRIV_M;
    if_sent = 0; ls_sent = 0; gi = 0; ri = 0;
    bus1.if_req_valid = 1'b1; bus1.if_req_addr = 32'h2000_0010;
    bus1.ls_req_valid = 1'b1; bus1.ls_req_addr = 32'h2000_0000; bus1.ls_req_we = 1'b1;
    for (int c = 0; c < 80 && ri < 6; c++) begin
      #1;
      adv_if = bus1.if_req_ready;
      adv_ls = bus1.ls_req_ready;
      chk("tie ready overlap", {31'd0, adv_if & adv_ls}, 0);
      if (adv_if || adv_ls) begin
        chk($sformatf("tie grant %0d", gi), {31'd0, adv_ls}, gi % 2);
        gi++;
      end
      if (bus1.if_rsp_valid || bus1.ls_rsp_valid) begin
        chk($sformatf("tie rsp port %0d", ri), {bus1.if_rsp_valid, bus1.ls_rsp_valid},
            (ri % 2) ? 2'b01 : 2'b10);
        chk($sformatf("tie rsp fault %0d", ri), {bus1.if_rsp_fault, bus1.ls_rsp_fault},
            (ri % 2) ? 2'b01 : 2'b00);
        ri++;
      end
      @(negedge clk);
      if (adv_if) begin
        if_sent++;
        if (if_sent == 3) bus1.if_req_valid = 1'b0;
        else bus1.if_req_addr = bus1.if_req_addr + 32'd4;
      end
      if (adv_ls) begin
        ls_sent++;
        if (ls_sent == 3) bus1.ls_req_valid = 1'b0;
        else bus1.ls_req_addr = bus1.ls_req_addr + 32'd4;
      end
    end
    chk("tie grant count", gi, 6);
    chk("tie rsp count", ri, 6);
    chk("tie fault count", f1_cnt, 3);

    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset("rst2");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].port, vecs[i].we, vecs[i].priv, vecs[i].addr, 1'b0, vecs[i].fault,
              $sformatf("v%0d", i));
      chk($sformatf("v%0d f_addr", i),  f1_addr,  vecs[i].f_addr);
      chk($sformatf("v%0d f_cause", i), f1_cause, vecs[i].cause);
      chk($sformatf("v%0d f_priv", i),  f1_priv,  vecs[i].f_priv);
      chk($sformatf("v%0d f_cnt", i),   f1_cnt,   vecs[i].cnt);
    end

    // Privilege drops to M while a U-mode fetch is in flight: U-mode result stands.
    run_req(1'b0, 1'b0, PRIV_U, 32'h1000_0100, 1'b1, 1'b1, "privsw");
    chk("privsw f_addr",  f1_addr,  32'h1000_0100);
    chk("privsw f_cause", f1_cause, FC_EXEC);
    chk("privsw f_priv",  f1_priv,  PRIV_U);
    chk("privsw f_cnt",   f1_cnt,   5);

    // Reset during CHECK aborts the check; the requester reissues afterwards.
    @(negedge clk);
    cur_priv = PRIV_U;
    bus1.ls_req_valid = 1'b1; bus1.ls_req_addr = 32'h1000_0200; bus1.ls_req_we = 1'b1;
    #1 chk("midrst ready", bus1.ls_req_ready, 1);
    @(negedge clk);
    bus1.ls_req_valid = 1'b0;
    #1 chk("midrst in check", m1_iss, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      chk($sformatf("midrst no rsp %0d", i), {bus1.if_rsp_valid, bus1.ls_rsp_valid}, 0);
    end
    run_req(1'b1, 1'b1, PRIV_U, 32'h1000_0200, 1'b0, 1'b1, "reissue");
    chk("reissue f_addr", f1_addr, 32'h1000_0200);
    chk("reissue f_cnt",  f1_cnt,  1);

    // MPU_LAT = 3, CNT_W = 2: five faulting stores saturate the counter at 3.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cur_priv = PRIV_U;
      bus2.ls_req_valid = 1'b1; bus2.ls_req_addr = MMIO_BASE; bus2.ls_req_we = 1'b1;
      #1 chk($sformatf("sat%0d ready", i), bus2.ls_req_ready, 1);
      @(negedge clk);
      bus2.ls_req_valid = 1'b0;
      k = 1;
      while (!bus2.ls_rsp_valid && k < 20) begin
        @(negedge clk); k++;
      end
      chk($sformatf("sat%0d latency", i), k, 4);
      chk($sformatf("sat%0d fault", i), bus2.ls_rsp_fault, 1);
      chk($sformatf("sat%0d cnt", i), f2_cnt, (i < 3) ? i + 1 : 3);
      @(negedge clk);
    end
    chk("sat f_cause", f2_cause, FC_STORE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpu_req_arbiter.md
Name: mpu_req_arbiter

Overview:
Shares the single `mpu` checker between the instruction-fetch port (IF) and the load/store port (LS). Accepts one request at a time using round-robin arbitration and drives the MPU check inputs for MPU_LAT cycles. It then samples allow/fault and returns a one-cycle response to the winning port. It also records the last fault (address, cause, privilege) and keeps a saturating fault count for the trap/CSR logic.

Parameters:
- MPU_LAT, 1, cycles from MPU inputs stable to fault outputs valid (must be ≥1).
- CNT_W, 16, width of the saturating fault counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cur_priv  in  priv_e  current hart privilege; latched at accept
- if_req_valid  in  1  fetch check request
- if_req_addr  in  32  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_fault  out  1  fetch denied (valid with if_rsp_valid)
- ls_req_valid  in  1  data check request
- ls_req_addr  in  32  data address
- ls_req_we  in  1  1 = store, 0 = load
- ls_req_ready  out  1  data request accepted this cycle
- ls_rsp_valid  out  1  data response pulse
- ls_rsp_fault  out  1  data denied
- mpu_addr  out  32  to mpu.addr
- mpu_is_fetch / mpu_is_load / mpu_is_store  out  1 each  to mpu
- mpu_cur_priv  out  priv_e  to mpu.cur_priv
- mpu_allow, mpu_fault_exec, mpu_fault_load, mpu_fault_store  in  1 each  from mpu
- fault_addr  out  32  address of most recent fault
- fault_cause  out  fault_cause_e  FC_NONE / FC_EXEC / FC_LOAD / FC_STORE
- fault_priv  out  priv_e  privilege of the faulting access
- fault_cnt  out  CNT_W  saturating count of faults

Behaviour:
- Reset values:
  - FSM = IDLE; all ready/rsp/mpu_is_* outputs = 0.
  - mpu_addr = 0; mpu_cur_priv = PRIV_M.
  - fault_addr = 0; fault_cause = FC_NONE; fault_priv = PRIV_M; fault_cnt = 0.
  - last_grant = LS, so IF wins the first tie.
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - ready is combinational. For the granted port, ready = its valid; the other port's ready = 0.
  - With a single requester, that requester is granted.
  - With both requesting, grant the port that is not last_grant.
  - On handshake (valid & ready at a clock edge): latch addr, type (fetch/load/store), cur_priv and port ID. Update last_grant, load lat_cnt = MPU_LAT-1, go to CHECK.
- CHECK:
  - Drive mpu_addr and mpu_cur_priv from the latched values.
  - Drive exactly one of mpu_is_* high according to the latched type.
  - Both readys = 0.
  - Decrement lat_cnt each cycle. At the edge where lat_cnt == 0, sample fault and go to RESP.
  - Sampled fault is `!mpu_allow | fault_exec` for a fetch, `| fault_load` for a load, `| fault_store` for a store.
- RESP:
  - Assert rsp_valid of the latched port for exactly one cycle, with the registered fault bit. mpu_is_* = 0.
  - Next state is IDLE.
  - No response back-pressure; requesters must accept the pulse.
- Latency:
  - Handshake at edge T; rsp_valid high in cycle T+1+MPU_LAT.
  - Throughput is one check per MPU_LAT+2 cycles.
- Outside CHECK, mpu_is_* = 0. mpu_addr and mpu_cur_priv hold their last values (no toggling).
- A change of cur_priv after accept has no effect on the in-flight check.
- Requests that are not granted must hold valid and addr stable until accepted. The block never drops a pending valid.
- Fault capture: on the edge that enters RESP with fault = 1, update fault_addr, fault_cause and fault_priv. Increment fault_cnt, saturating at 2^CNT_W-1. The registers are unchanged on an allowed access.
- Async reset mid-CHECK or mid-RESP aborts the operation. No response is emitted, and the requester reissues.

Decomposition:
- Package `harvos_pkg`, shared with `mpu`, holds:
  - existing `priv_e` (PRIV_U, PRIV_M);
  - new `fault_cause_e` (2 bits: FC_NONE, FC_EXEC, FC_LOAD, FC_STORE);
  - `acc_type_e` (ACC_FETCH, ACC_LOAD, ACC_STORE);
  - localparam MMIO_BASE = 32'h1000_0000.
- One natural sub-module, `rr_arb2`: a 2-way round-robin grant with a last_grant register, reusable by the bus fabric.
- The FSM, latency counter and fault registers stay in the top.

Test Plan:
- PRIV_U, LS store to 32'h1000_0000 (real `mpu`, MPU_LAT=1):
  - ls_rsp_valid pulses in cycle T+2 with ls_rsp_fault=1;
  - fault_addr=32'h1000_0000, fault_cause=FC_STORE, fault_priv=PRIV_U, fault_cnt=1.
- PRIV_M, LS load to 32'h1000_0000: ls_rsp_fault=0; fault_cnt stays 0; fault_cause stays FC_NONE.
- IF and LS valid in the same cycle, three times each, held until accepted:
  - grants alternate IF, LS, IF, LS, IF, LS;
  - each response lands on the correct port;
  - if_req_ready and ls_req_ready are never high together.
- PRIV_U fetch accepted, then cur_priv switched to PRIV_M during CHECK: mpu_cur_priv stays PRIV_U and the result matches the U-mode check.
- rst_n pulsed low during CHECK:
  - all outputs return to their reset values asynchronously;
  - no rsp_valid is seen;
  - the reissued request completes normally.
- CNT_W=2 with five faulting U-mode stores: fault_cnt reads 1, 2, 3, 3, 3.
